dsp_mult_arbiter: RTL

//  Shares one pipelined signed 18x18 DSP multiplier between NREQ requesters.
//  - Round-robin grant of the multiplier, at most one issue per cycle.
//  - Credit-controlled output FIFO so that no result is ever dropped under backpressure.
//  - Each result is tagged with the requester ID; optional per-requester accumulation.
//  - Sits between LIFCL DSP-using logic and the MULT18X18/MULTADDSUB datapath it configures.

---
 rtl/dsp_mult_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dsp_mult_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier, with a credit-guarded FWFT result FIFO.
// Define DSP_ARB_ACC_EN to add per-requester accumulators updated at pipeline exit.
module dsp_mult_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 18,
    parameter int BW   = 18,
    parameter int PIPE = 3,
    parameter int ACCW = 48
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*AW-1:0]      req_a,
    input  logic [NREQ*BW-1:0]      req_b,
    input  logic [NREQ-1:0]         req_acc,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [ACCW-1:0]         res_data,
    output logic                    busy
);
    localparam int IDW   = $clog2(NREQ);
    localparam int DEPTH = PIPE + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [PIPE-1:0] pv_q, pv_d;
    logic [IDW-1:0]  pid_q [PIPE];
    logic [AW-1:0]   pa_q  [PIPE];
    logic [BW-1:0]   pb_q  [PIPE];
    logic [IDW-1:0]  fid_q   [DEPTH];
    logic [ACCW-1:0] fdata_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [IDW-1:0]  win, cand;
    logic            win_found, has_credit, issue, push, pop;

    logic signed [AW+BW-1:0] prod_full;
    logic [ACCW-1:0]         prod_ext, ex_data;

    // Round-robin search starting at the pointer; credit covers both in-flight ops and FIFO entries.
    always_comb begin
        win       = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
        has_credit = ($countones(pv_q) + int'(cnt_q)) < DEPTH;
        issue      = win_found && has_credit;
        req_ready  = '0;
        if (issue) req_ready[win] = 1'b1;
        ptr_d = ptr_q;
        if (issue) ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        pv_d    = '0;
        pv_d[0] = issue;
        for (int unsigned s = 1; s < PIPE; s++) pv_d[s] = pv_q[s-1];
    end

    always_ff @(posedge CLK) begin
        for (int unsigned s = PIPE - 1; s > 0; s--) begin
            pid_q[s] <= pid_q[s-1];
            pa_q[s]  <= pa_q[s-1];
            pb_q[s]  <= pb_q[s-1];
        end
        pid_q[0] <= win;
        pa_q[0]  <= req_a[32'(win)*AW +: AW];
        pb_q[0]  <= req_b[32'(win)*BW +: BW];
    end

    assign prod_full = $signed(pa_q[PIPE-1]) * $signed(pb_q[PIPE-1]);
    assign prod_ext  = ACCW'(prod_full);
    assign push      = pv_q[PIPE-1];

`ifdef DSP_ARB_ACC_EN
    logic [PIPE-1:0] pacc_q, pacc_d;
    logic [ACCW-1:0] acc_q [NREQ];
    logic [ACCW-1:0] acc_d [NREQ];

    always_comb begin
        pacc_d    = '0;
        pacc_d[0] = req_acc[win];
        for (int unsigned s = 1; s < PIPE; s++) pacc_d[s] = pacc_q[s-1];
        acc_d   = acc_q;
        ex_data = prod_ext;
        if (pacc_q[PIPE-1]) ex_data = acc_q[pid_q[PIPE-1]] + prod_ext;
        if (push) acc_d[pid_q[PIPE-1]] = ex_data;
    end

    always_ff @(posedge CLK) begin
        pacc_q <= pacc_d;
        if (RST) acc_q <= '{default: '0};
        else     acc_q <= acc_d;
    end
`else
    logic unused_acc;
    assign unused_acc = ^req_acc;
    assign ex_data    = prod_ext;
`endif

    assign res_valid = (cnt_q != '0);
    assign pop       = res_valid && res_ready;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fid_q[wr_q]   <= pid_q[PIPE-1];
            fdata_q[wr_q] <= ex_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            pv_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            pv_q  <= pv_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Head is masked when empty so the idle outputs read as zero.
    assign res_id   = res_valid ? fid_q[rd_q]   : '0;
    assign res_data = res_valid ? fdata_q[rd_q] : '0;
    assign busy     = (pv_q != '0) || res_valid;

endmodule
